// File: rtl/vga_video_adapter_if.sv
// rtl/vga_video_adapter_if.sv - raw game-core video in, framework video and timing status out
interface vga_video_adapter_if;
    logic        hs_in;
    logic        vs_in;
    logic [3:0]  r_in;
    logic [3:0]  g_in;
    logic [3:0]  b_in;
    logic        ce_pix;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_de;
    logic        hblank;
    logic        vblank;
    logic        locked;
    logic [11:0] h_total;
    logic [10:0] v_total;

    // master is the game-core/framework side, slave is the adapter
    modport master (
        output hs_in, vs_in, r_in, g_in, b_in,
        input  ce_pix, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de,
        input  hblank, vblank, locked, h_total, v_total
    );

    modport slave (
        input  hs_in, vs_in, r_in, g_in, b_in,
        output ce_pix, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de,
        output hblank, vblank, locked, h_total, v_total
    );
endinterface

// File: rtl/vga_video_adapter.sv
// rtl/vga_video_adapter.sv - pixel enable, blanking/DE reconstruction from sync edges, colour expansion, timing lock
module vga_video_adapter #(
    parameter int CE_DIV   = 4,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480
) (
    input  logic               clk_sys,
    input  logic               reset,
    vga_video_adapter_if.slave vid
);
    localparam int               DIV_W    = $clog2(CE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);
    localparam logic             HS_ACT   = (HS_POL != 0);
    localparam logic             VS_ACT   = (VS_POL != 0);
    localparam logic [11:0]      H_START  = 12'(H_BP);
    localparam logic [11:0]      H_END    = 12'(H_BP + H_ACTIVE);
    localparam logic [10:0]      V_START  = 11'(V_BP);
    localparam logic [10:0]      V_END    = 11'(V_BP + V_ACTIVE);
    localparam logic [11:0]      H_MAX    = '1;
    localparam logic [10:0]      V_MAX    = '1;

    logic [DIV_W-1:0] div;
    logic             tick;
    logic             hs_s1, vs_s1;
    logic [3:0]       r_s1, g_s1, b_s1;
    logic [11:0]      h_cnt, h_inc, h_total;
    logic [10:0]      v_cnt, v_inc, v_total;
    logic             seen_vs, h_mismatch, locked, locked_next;
    logic             hs_te, vs_te, h_mm, lock_ok;
    logic             h_act, v_act, de_next;
    logic [7:0]       vga_r, vga_g, vga_b;
    logic             vga_hs, vga_vs, vga_de, hblank, vblank;

    assign tick = (div == DIV_LAST);

    always_ff @(posedge clk_sys) begin
        if (reset || tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Edges compare the held sample with the one arriving this tick, so the
    // counters stay aligned with the stage-1 pixel they describe.
    always_comb begin
        hs_te       = (hs_s1 == HS_ACT) && (vid.hs_in != HS_ACT);
        vs_te       = (vs_s1 == VS_ACT) && (vid.vs_in != VS_ACT);
        h_inc       = (h_cnt == H_MAX) ? h_cnt : h_cnt + 12'd1;
        v_inc       = (v_cnt == V_MAX) ? v_cnt : v_cnt + 11'd1;
        h_mm        = hs_te && (h_inc != h_total);
        lock_ok     = seen_vs && (v_cnt == v_total) && (v_cnt >= V_END)
                      && !h_mismatch && !h_mm;
        locked_next = vs_te ? lock_ok : locked;
        if (!hs_te && (h_inc == H_MAX)) begin
            locked_next = 1'b0;
        end
        h_act       = (h_cnt >= H_START) && (h_cnt < H_END);
        v_act       = seen_vs && (v_cnt >= V_START) && (v_cnt < V_END);
        de_next     = h_act && v_act && locked;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hs_s1      <= ~HS_ACT;
            vs_s1      <= ~VS_ACT;
            r_s1       <= '0;
            g_s1       <= '0;
            b_s1       <= '0;
            h_cnt      <= '0;
            v_cnt      <= '0;
            h_total    <= '0;
            v_total    <= '0;
            seen_vs    <= 1'b0;
            h_mismatch <= 1'b0;
            locked     <= 1'b0;
            vga_r      <= '0;
            vga_g      <= '0;
            vga_b      <= '0;
            vga_hs     <= 1'b0;
            vga_vs     <= 1'b0;
            vga_de     <= 1'b0;
            hblank     <= 1'b0;
            vblank     <= 1'b0;
        end else if (tick) begin
            hs_s1 <= vid.hs_in;
            vs_s1 <= vid.vs_in;
            r_s1  <= vid.r_in;
            g_s1  <= vid.g_in;
            b_s1  <= vid.b_in;

            if (hs_te) begin
                h_total <= h_inc;
                h_cnt   <= '0;
            end else begin
                h_cnt   <= h_inc;
            end

            // A coincident hsync edge belongs to the new frame: vsync wins.
            if (vs_te) begin
                v_total <= v_cnt;
                v_cnt   <= '0;
                seen_vs <= 1'b1;
            end else if (hs_te) begin
                v_cnt   <= v_inc;
            end

            h_mismatch <= vs_te ? 1'b0 : (h_mismatch || h_mm);
            locked     <= locked_next;

            vga_hs <= hs_s1;
            vga_vs <= vs_s1;
            vga_de <= de_next;
            hblank <= ~h_act;
            vblank <= ~v_act;
            vga_r  <= de_next ? {r_s1, r_s1} : 8'h00;
            vga_g  <= de_next ? {g_s1, g_s1} : 8'h00;
            vga_b  <= de_next ? {b_s1, b_s1} : 8'h00;
        end
    end

    assign vid.ce_pix  = tick;
    assign vid.vga_r   = vga_r;
    assign vid.vga_g   = vga_g;
    assign vid.vga_b   = vga_b;
    assign vid.vga_hs  = vga_hs;
    assign vid.vga_vs  = vga_vs;
    assign vid.vga_de  = vga_de;
    assign vid.hblank  = hblank;
    assign vid.vblank  = vblank;
    assign vid.locked  = locked;
    assign vid.h_total = h_total;
    assign vid.v_total = v_total;
endmodule
